// File: rtl/key_decoder.sv
// key_decoder: turns PS/2 set-2 scan-code bytes into held key levels for
// space (29), left arrow (E0 6B) and right arrow (E0 74).
// A four-state prefix FSM tracks E0/F0. One hold bit per key sits behind a
// registered output stage, so the output follows the hold bit one edge later.
// Optional feature: define KEY_TIMEOUT_EN to clear stale hold bits after
// TIMEOUT_CYCLES idle cycles. This recovers from a lost break code.
module key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right
);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t state_q, state_d;
  logic   hold_space_q, hold_space_d;
  logic   hold_left_q,  hold_left_d;
  logic   hold_right_q, hold_right_d;
  logic   expire;

`ifdef KEY_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_hold;

  // Stale-key counter: reload on every byte, count down while a key is held
  always_comb begin
    any_hold = hold_space_q | hold_left_q | hold_right_q;
    cnt_d    = cnt_q;
    expire   = 1'b0;
    if (rx_valid) begin
      cnt_d = CNT_RELOAD;
    end else if (any_hold) begin
      // Clearing the holds on the same edge that the counter reaches zero
      expire = (cnt_q <= CNT_ONE);
      cnt_d  = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  // Prefix FSM and hold-bit next state; bytes are consumed only on rx_valid
  always_comb begin
    state_d      = state_q;
    hold_space_d = hold_space_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == CODE_EXT)        state_d = S_EXT;
          else if (rx_data == CODE_BRK)   state_d = S_BRK;
          else if (rx_data == CODE_SPACE) hold_space_d = 1'b1;
        end
        S_EXT: begin
          state_d = S_IDLE;
          if (rx_data == CODE_BRK)        state_d = S_EXT_BRK;
          else if (rx_data == CODE_EXT)   state_d = S_EXT;
          else if (rx_data == CODE_LEFT)  hold_left_d = 1'b1;
          else if (rx_data == CODE_RIGHT) hold_right_d = 1'b1;
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (rx_data == CODE_SPACE) hold_space_d = 1'b0;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (rx_data == CODE_LEFT)       hold_left_d = 1'b0;
          else if (rx_data == CODE_RIGHT) hold_right_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (expire) begin
      state_d      = S_IDLE;
      hold_space_d = 1'b0;
      hold_left_d  = 1'b0;
      hold_right_d = 1'b0;
    end
  end

  // State, hold bits and registered outputs; conflicting arrows both read 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      hold_space_q <= 1'b0;
      hold_left_q  <= 1'b0;
      hold_right_q <= 1'b0;
      key_space    <= 1'b0;
      key_left     <= 1'b0;
      key_right    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_space_q <= hold_space_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      key_space    <= hold_space_q;
      key_left     <= hold_left_q & ~hold_right_q;
      key_right    <= hold_right_q & ~hold_left_q;
    end
  end

endmodule

// File: tb/tb_key_decoder.sv
// Directed bench for key_decoder. Outputs are checked as {space,left,right}.
// Timeout checks are built only when KEY_TIMEOUT_EN is defined.
module tb_key_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       key_space, key_left, key_right;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  key_decoder #(.TIMEOUT_CYCLES(50)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .key_space(key_space),
    .key_left (key_left),
    .key_right(key_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sp,l,r}=%b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] keys();
    return {key_space, key_left, key_right};
  endfunction

  // One strobe, driven on the falling edge and captured on the next rising edge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Let the output register catch up after the last strobe
  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("in_reset", keys(), 3'b000);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_100", keys(), 3'b000);

    // Latency: nothing after the first edge, output after the second edge
    @(negedge clk);
    rx_data = 8'h29; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("space_lat1", keys(), 3'b000);
    @(posedge clk); #1;
    check("space_lat2", keys(), 3'b100);

    send(8'hF0); settle();
    check("brk_prefix_only", keys(), 3'b100);
    send(8'h29); settle();
    check("space_release", keys(), 3'b000);

    // Typematic repeat
    send(8'h29); send(8'h29); send(8'h29); settle();
    check("space_repeat", keys(), 3'b100);
    send(8'hF0); send(8'h29); settle();
    check("space_release2", keys(), 3'b000);

    // Arrows and conflict
    send(8'hE0); settle();
    check("ext_prefix_only", keys(), 3'b000);
    send(8'h74); settle();
    check("right_make", keys(), 3'b001);
    send(8'hE0); send(8'h6B); settle();
    check("both_conflict", keys(), 3'b000);
    send(8'hE0); send(8'hF0); settle();
    check("ext_brk_prefix", keys(), 3'b000);
    send(8'h74); settle();
    check("right_break", keys(), 3'b010);
    send(8'hE0); send(8'hF0); send(8'h6B); settle();
    check("left_break", keys(), 3'b000);

    // Non-extended keypad codes ignored; aborted E0 12 returns to IDLE
    send(8'h6B); send(8'h74); settle();
    check("keypad_ignored", keys(), 3'b000);
    send(8'hE0); send(8'h12); send(8'h29); settle();
    check("abort_then_space", keys(), 3'b100);
    // Break of a non-key aborts cleanly
    send(8'hF0); send(8'h12); send(8'h6B); settle();
    check("brk_other", keys(), 3'b100);
    // Repeated E0 stays extended
    send(8'hE0); send(8'hE0); send(8'h6B); settle();
    check("ext_ext_left", keys(), 3'b110);

    // Back-to-back strobes: E0 F0 6B then F0 29 on consecutive cycles
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'hE0;
    @(negedge clk); rx_data = 8'hF0;
    @(negedge clk); rx_data = 8'h6B;
    @(negedge clk); rx_data = 8'hF0;
    @(negedge clk); rx_data = 8'h29;
    @(negedge clk); rx_valid = 1'b0; rx_data = 8'h00;
    settle();
    check("back_to_back", keys(), 3'b000);

    // Reset in mid-sequence discards the prefix and clears the holds
    send(8'h29); send(8'hE0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("mid_reset", keys(), 3'b000);
    rst = 1'b1;
    send(8'h6B); settle();
    check("after_reset_6b", keys(), 3'b000);
    send(8'hE0); send(8'h74); settle();
    check("after_reset_right", keys(), 3'b001);
    send(8'hE0); send(8'hF0); send(8'h74); settle();
    check("after_reset_rel", keys(), 3'b000);

`ifdef KEY_TIMEOUT_EN
    // Strobe captured at edge 0; holds clear at edge 50, output at edge 51
    @(negedge clk); rx_data = 8'h29; rx_valid = 1'b1;
    @(posedge clk); #1; rx_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1 check("timeout_edge50", keys(), 3'b100);
    @(posedge clk); #1;
    check("timeout_edge51", keys(), 3'b000);
    // Keep-alive every 40 cycles
    send(8'h29);
    for (int i = 0; i < 3; i++) begin
      repeat (38) @(negedge clk);
      send(8'h29);
    end
    repeat (30) @(negedge clk);
    check("keepalive", keys(), 3'b100);
    repeat (30) @(negedge clk);
    check("keepalive_expire", keys(), 3'b000);
`else
    send(8'h29);
    repeat (200) @(negedge clk);
    check("no_timeout_hold", keys(), 3'b100);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_decoder.md
# key_decoder

Converts the byte stream from the PS/2 receiver into held key levels `key_space`, `key_left`, `key_right` for `draw_rect_ctl`, which sits directly downstream. It tracks set-2 make/break/extended prefixes with a small state machine and keeps one registered hold bit per key. The outputs are level signals that stay high for as long as the physical key is held.

## Interface
- `TIMEOUT_CYCLES`, default 65_000_000: stale-key timeout in `clk` cycles (1 s at 65 MHz); used only when `KEY_TIMEOUT_EN` is defined.
- `clk` input 1: system clock, same 65 MHz domain as `draw_rect_ctl`.
- `rst` input 1: asynchronous, active-low reset.
- `rx_data` input 8: received scan-code byte; valid only when `rx_valid` = 1.
- `rx_valid` input 1: one-cycle strobe per received byte; back-to-back strobes are legal.
- `key_space` output 1: space held (scan code 0x29).
- `key_left` output 1: left arrow held (E0 6B).
- `key_right` output 1: right arrow held (E0 74).

## Operation
- Four-state decoder FSM: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Bytes are consumed only on `rx_valid` = 1.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - 0x29 → set `hold_space`.
  - Any other byte is ignored and the FSM stays in IDLE.
- EXT:
  - F0 → EXT_BRK.
  - 6B → set `hold_left`, go to IDLE.
  - 74 → set `hold_right`, go to IDLE.
  - E0 → stay in EXT.
  - Any other byte → IDLE, no effect.
- BRK: 0x29 clears `hold_space`. Any byte returns the FSM to IDLE.
- EXT_BRK: 6B clears `hold_left`; 74 clears `hold_right`. Any byte returns the FSM to IDLE.
- Non-extended 6B and 74 (keypad 4 and 6) are ignored.
- Repeated make codes from typematic repeat re-set an already-set bit; this has no visible effect.
- Output rule:
  - `key_space` = `hold_space`.
  - `key_left` = `hold_left` & ~`hold_right`.
  - `key_right` = `hold_right` & ~`hold_left`.
  - Both arrows held → both arrow outputs 0.
- All outputs are registered. No combinational path from `rx_data` to any output.

## Timing
- Reset (`rst` = 0): FSM goes to IDLE; all hold bits, all outputs, and the timeout counter go to 0.
- Latency: the output updates on the second rising edge after the `rx_valid` edge carrying the final byte of a sequence. That is one edge to update the hold bit and one edge for the output register.
- Prefix bytes (E0, F0) never change any output.
- If reset is asserted in mid-sequence (e.g. after E0), the partial prefix is discarded. The next byte after reset is decoded from IDLE.
- Back-to-back `rx_valid` strobes are each decoded on consecutive cycles, with no byte lost.
- Unknown bytes in a prefix state abort the sequence, per the rules above. The decoder never locks up.

## Configuration
- `KEY_TIMEOUT_EN` defined:
  - A down-counter of width $clog2(`TIMEOUT_CYCLES`+1) reloads to `TIMEOUT_CYCLES` on every `rx_valid`.
  - While any hold bit is 1 and no byte arrives, the counter decrements by one per cycle.
  - On reaching 0, all hold bits clear in the same cycle and the FSM returns to IDLE. This recovers from a lost break code; typematic repeat keeps a held key alive.
- `KEY_TIMEOUT_EN` undefined: no counter is built, and hold bits clear only on break codes or reset.

## Test plan
- Reset release, no bytes for 100 cycles → all three outputs 0 and FSM in IDLE.
- Bytes 29 → `key_space` = 1 two edges after the strobe; then F0 29 → `key_space` = 0. F0 alone leaves `key_space` = 1.
- E0 74 → `key_right` = 1; then E0 6B → `key_left` = 0 and `key_right` = 0 (conflict); then E0 F0 74 → `key_left` = 1 and `key_right` = 0.
- Non-extended 6B and 74, plus E0 12 followed by 29 → no arrow output set; `key_space` = 1 (abort leaves the FSM in IDLE).
- Reset pulse between E0 and 6B → after reset, 6B is ignored and `key_left` stays 0.
- With `KEY_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 50: send 29, then wait 51 cycles → `key_space` drops to 0. Repeating 29 every 40 cycles keeps it at 1.
